// File: rtl/asap1_pkg.sv
// Shared constants for the asap1 SAP-1 style core:
// control-word bit positions, opcodes and step indices.
package asap1_pkg;

    localparam int CONTROL_SIGNALS = 15;

    localparam int AI  = 0;
    localparam int AO  = 1;
    localparam int BI  = 2;
    localparam int BO  = 3;
    localparam int MAI = 4;
    localparam int OUI = 5;
    localparam int II  = 6;
    localparam int ALO = 7;
    localparam int ALS = 8;
    localparam int PCI = 9;
    localparam int PCO = 10;
    localparam int PCS = 11;
    localparam int MI  = 12;
    localparam int MO  = 13;
    localparam int HLT = 14;

    typedef logic [CONTROL_SIGNALS-1:0] ctrl_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_STA = 8'h04;
    localparam logic [7:0] OP_LDI = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h06;
    localparam logic [7:0] OP_JC  = 8'h07;
    localparam logic [7:0] OP_JZ  = 8'h08;
    localparam logic [7:0] OP_OUT = 8'h0E;
    localparam logic [7:0] OP_HLT = 8'h0F;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    // Opcodes that need steps beyond the two fetch cycles.
    function automatic logic multi_step(input logic [7:0] op);
        return (op >= OP_LDA && op <= OP_JZ) || op == OP_OUT || op == OP_HLT;
    endfunction

endpackage

// File: rtl/asap1_alu.sv
// Add/subtract unit with carry and zero flags; the flags
// update only on cycles where the result is driven to the bus.
module asap1_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic       load,
    output logic [7:0] y,
    output logic       cf,
    output logic       zf
);

    logic [8:0] sum;

    assign sum = {1'b0, a} + {1'b0, sub ? ~b : b} + {8'd0, sub};
    assign y   = sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf <= 1'b0;
            zf <= 1'b0;
        end else if (load) begin
            cf <= sum[8];
            zf <= (sum[7:0] == 8'h00);
        end
    end

endmodule

// File: rtl/asap1_cpu.sv
// SAP-1 style 8-bit CPU: microcoded control, single bus,
// registers and program RAM loaded while in reset.
module asap1_cpu
    import asap1_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] out,
    output logic       halted,
    output logic [7:0] pc
);

    logic [7:0] a, b, mar, ir;
    logic [7:0] bus, alu_y, mem_rd;
    logic [2:0] step;
    logic       cf, zf, last, jmp_ok;
    ctrl_t      cw, ctrl;
    logic [7:0] ram [MEM_DEPTH];

    assign mem_rd = (int'(mar) < MEM_DEPTH) ? ram[mar] : 8'h00;
    assign jmp_ok = (ir == OP_JC && cf) || (ir == OP_JZ && zf);

    // At T1 the new opcode is only on the bus, so the end-of-fetch
    // decision for one-step opcodes looks at the RAM read directly.
    always_comb begin
        cw   = '0;
        last = 1'b0;
        case (step)
            T0: begin
                cw[PCO] = 1'b1;
                cw[MAI] = 1'b1;
            end
            T1: begin
                cw[MO]  = 1'b1;
                cw[II]  = 1'b1;
                cw[PCS] = 1'b1;
                last    = !multi_step(mem_rd);
            end
            T2: case (ir)
                OP_OUT: begin
                    cw[AO]  = 1'b1;
                    cw[OUI] = 1'b1;
                    last    = 1'b1;
                end
                OP_HLT: cw[HLT] = 1'b1;
                OP_JC, OP_JZ: begin
                    if (jmp_ok) begin
                        cw[PCO] = 1'b1;
                        cw[MAI] = 1'b1;
                    end else begin
                        cw[PCS] = 1'b1;
                        last    = 1'b1;
                    end
                end
                OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP: begin
                    cw[PCO] = 1'b1;
                    cw[MAI] = 1'b1;
                end
                default: last = 1'b1;
            endcase
            T3: case (ir)
                OP_LDI: begin
                    cw[MO]  = 1'b1;
                    cw[AI]  = 1'b1;
                    cw[PCS] = 1'b1;
                    last    = 1'b1;
                end
                OP_JMP, OP_JC, OP_JZ: begin
                    cw[MO]  = 1'b1;
                    cw[PCI] = 1'b1;
                    last    = 1'b1;
                end
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    cw[MO]  = 1'b1;
                    cw[MAI] = 1'b1;
                    cw[PCS] = 1'b1;
                end
                default: last = 1'b1;
            endcase
            T4: case (ir)
                OP_LDA: begin
                    cw[MO] = 1'b1;
                    cw[AI] = 1'b1;
                    last   = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw[MO] = 1'b1;
                    cw[BI] = 1'b1;
                end
                OP_STA: begin
                    cw[AO] = 1'b1;
                    cw[MI] = 1'b1;
                    last   = 1'b1;
                end
                default: last = 1'b1;
            endcase
            T5: begin
                last = 1'b1;
                if (ir == OP_ADD || ir == OP_SUB) begin
                    cw[ALO] = 1'b1;
                    cw[ALS] = (ir == OP_SUB);
                    cw[AI]  = 1'b1;
                end
            end
            default: last = 1'b1;
        endcase
    end

    assign ctrl = halted ? '0 : cw;

    always_comb begin
        bus = 8'h00;
        unique case (1'b1)
            ctrl[AO]:  bus = a;
            ctrl[BO]:  bus = b;
            ctrl[ALO]: bus = alu_y;
            ctrl[PCO]: bus = pc;
            ctrl[MO]:  bus = mem_rd;
            default:   bus = 8'h00;
        endcase
    end

    asap1_alu u_alu (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .sub  (ctrl[ALS]),
        .load (ctrl[ALO]),
        .y    (alu_y),
        .cf   (cf),
        .zf   (zf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= 8'h00;
            b      <= 8'h00;
            mar    <= 8'h00;
            ir     <= 8'h00;
            out    <= 8'h00;
            pc     <= 8'h00;
            step   <= T0;
            halted <= 1'b0;
        end else begin
            if (ctrl[AI])  a   <= bus;
            if (ctrl[BI])  b   <= bus;
            if (ctrl[MAI]) mar <= bus;
            if (ctrl[II])  ir  <= bus;
            if (ctrl[OUI]) out <= bus;
            if (ctrl[PCI]) pc <= bus;
            else if (ctrl[PCS]) pc <= pc + 8'd1;
            if (ctrl[HLT]) halted <= 1'b1;
            if (!(halted || ctrl[HLT])) step <= last ? T0 : step + 3'd1;
        end
    end

    // RAM contents survive reset; reset only switches the write source.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (prog_we && int'(prog_addr) < MEM_DEPTH) ram[prog_addr] <= prog_data;
        end else if (ctrl[MI] && int'(mar) < MEM_DEPTH) begin
            ram[mar] <= bus;
        end
    end

endmodule

// File: tb/tb_asap1_cpu.sv
// Bench for asap1_cpu: directed program table, reset abort
// sequence and random programs against an instruction-level model.
module tb_asap1_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'h00;
    logic [7:0] prog_data = 8'h00;
    logic [7:0] out, pc;
    logic       halted;

    asap1_cpu #(.MEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out       (out),
        .halted    (halted),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] img [256];
    logic [7:0] progs [6][64];

    typedef struct {
        int         p;
        int         cycles;
        logic [7:0] out;
        logic [7:0] pc;
        logic       halted;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic put(input int p, input int addr, input logic [63:0] bytes, input int n);
        for (int k = 0; k < n; k++) progs[p][addr+k] = bytes[8*(n-1-k) +: 8];
    endtask

    task automatic load_and_reset(input string tag);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = img[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
        check({tag, " rst out"}, out, 8'h00);
        check({tag, " rst pc"}, pc, 8'h00);
        check({tag, " rst halted"}, {7'd0, halted}, 8'h00);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic random_program(input int id);
        int         n;
        int         starts[$];
        logic [7:0] ops[$];
        logic [7:0] choice [11];
        logic [7:0] mem [256];
        int         a, mpc, mout, cf, zf, cyc, r, taken, addr;
        logic [7:0] op, opd;
        string      tag;
        choice = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                   8'h06, 8'h07, 8'h08, 8'h0E, 8'h0B};
        n = $urandom_range(8, 16);
        addr = 0;
        for (int i = 0; i < n; i++) begin
            op = (i == n - 1) ? 8'h0F : choice[$urandom_range(0, 10)];
            ops.push_back(op);
            starts.push_back(addr);
            addr += (op == 8'h00 || op == 8'h0E || op == 8'h0B || op == 8'h0F) ? 1 : 2;
        end
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        for (int k = 8'h80; k < 8'hA0; k++) img[k] = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            img[starts[i]] = ops[i];
            unique case (ops[i])
                8'h06, 8'h07, 8'h08:
                    img[starts[i]+1] = 8'(starts[$urandom_range(i + 1, n - 1)]);
                8'h05: img[starts[i]+1] = 8'($urandom);
                8'h01, 8'h02, 8'h03, 8'h04:
                    img[starts[i]+1] = 8'(8'h80 + $urandom_range(0, 31));
                default: ;
            endcase
        end
        tag = $sformatf("rnd%0d", id);
        load_and_reset(tag);
        mem = img;
        a = 0; mpc = 0; mout = 0; cf = 0; zf = 0;
        for (int s = 0; s < 64; s++) begin
            op  = mem[mpc];
            opd = mem[(mpc + 1) % 256];
            cyc = 2;
            case (op)
                8'h01: begin a = mem[opd]; cyc = 5; mpc += 2; end
                8'h02, 8'h03: begin
                    r = (op == 8'h02) ? a + mem[opd] : a + (255 - mem[opd]) + 1;
                    cf = (r > 255) ? 1 : 0;
                    a = r % 256;
                    zf = (a == 0) ? 1 : 0;
                    cyc = 6; mpc += 2;
                end
                8'h04: begin mem[opd] = 8'(a); cyc = 5; mpc += 2; end
                8'h05: begin a = opd; cyc = 4; mpc += 2; end
                8'h06: begin mpc = opd; cyc = 4; end
                8'h07, 8'h08: begin
                    taken = (op == 8'h07) ? cf : zf;
                    cyc = taken ? 4 : 3;
                    mpc = taken ? int'(opd) : mpc + 2;
                end
                8'h0E: begin mout = a; cyc = 3; mpc += 1; end
                8'h0F: begin cyc = 3; mpc += 1; end
                default: begin cyc = 2; mpc += 1; end
            endcase
            mpc = mpc % 256;
            run(cyc);
            check($sformatf("%s i%0d pc", tag, s), pc, 8'(mpc));
            check($sformatf("%s i%0d out", tag, s), out, 8'(mout));
            check($sformatf("%s i%0d halted", tag, s), {7'd0, halted},
                  (op == 8'h0F) ? 8'h01 : 8'h00);
            if (op == 8'h0F) begin
                run(5);
                check({tag, " held pc"}, pc, 8'(mpc));
                break;
            end
        end
    endtask

    initial begin
        for (int p = 0; p < 6; p++)
            for (int k = 0; k < 64; k++) progs[p][k] = 8'h00;
        put(0, 8'h00, 64'h05_05_02_20_0E_0F, 6);
        put(0, 8'h20, 64'h03, 1);
        put(1, 8'h00, 64'h05_03_03_20_08_10, 6);
        put(1, 8'h10, 64'h07_30, 2);
        put(1, 8'h20, 64'h03, 1);
        put(1, 8'h30, 64'h0E_0F, 2);
        put(2, 8'h00, 64'h05_02_03_20_07_10_08_12, 8);
        put(2, 8'h08, 64'h0E_0F, 2);
        put(2, 8'h20, 64'h03, 1);
        put(3, 8'h00, 64'h05_FF_02_20_07_30, 6);
        put(3, 8'h20, 64'h01, 1);
        put(3, 8'h30, 64'h0E_08_34_00_0F, 5);
        put(4, 8'h00, 64'h05_5A_04_40_05_00_01_40, 8);
        put(4, 8'h08, 64'h0E_0F, 2);
        put(5, 8'h00, 64'h00_0B_05_07_0E_0F, 6);

        vecs.push_back('{0, 13, 8'h08, 8'h05, 1'b0});
        vecs.push_back('{0, 16, 8'h08, 8'h06, 1'b1});
        vecs.push_back('{0, 30, 8'h08, 8'h06, 1'b1});
        vecs.push_back('{1, 14, 8'h00, 8'h10, 1'b0});
        vecs.push_back('{1, 18, 8'h00, 8'h30, 1'b0});
        vecs.push_back('{1, 24, 8'h00, 8'h32, 1'b1});
        vecs.push_back('{2, 13, 8'h00, 8'h06, 1'b0});
        vecs.push_back('{2, 16, 8'h00, 8'h08, 1'b0});
        vecs.push_back('{2, 19, 8'hFF, 8'h09, 1'b0});
        vecs.push_back('{2, 22, 8'hFF, 8'h0A, 1'b1});
        vecs.push_back('{3, 14, 8'h00, 8'h30, 1'b0});
        vecs.push_back('{3, 21, 8'h00, 8'h34, 1'b0});
        vecs.push_back('{3, 24, 8'h00, 8'h35, 1'b1});
        vecs.push_back('{4, 21, 8'h5A, 8'h09, 1'b0});
        vecs.push_back('{4, 24, 8'h5A, 8'h0A, 1'b1});
        vecs.push_back('{5, 11, 8'h07, 8'h05, 1'b0});
        vecs.push_back('{5, 14, 8'h07, 8'h06, 1'b1});

        foreach (vecs[i]) begin
            for (int k = 0; k < 256; k++) img[k] = (k < 64) ? progs[vecs[i].p][k] : 8'h00;
            load_and_reset($sformatf("v%0d", i));
            run(vecs[i].cycles);
            check($sformatf("v%0d out", i), out, vecs[i].out);
            check($sformatf("v%0d pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d halted", i), {7'd0, halted}, {7'd0, vecs[i].halted});
        end

        for (int k = 0; k < 256; k++) img[k] = (k < 64) ? progs[0][k] : 8'h00;
        load_and_reset("abort");
        run(16);
        check("abort pre out", out, 8'h08);
        rst = 1'b1;
        #1;
        check("abort async out", out, 8'h00);
        check("abort async pc", pc, 8'h00);
        check("abort async halted", {7'd0, halted}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run(8);
        check("abort t4 pc", pc, 8'h04);
        rst = 1'b1;
        #1;
        check("abort mid pc", pc, 8'h00);
        check("abort mid out", out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run(13);
        check("rerun out", out, 8'h08);
        check("rerun pc", pc, 8'h05);
        run(3);
        check("rerun halted", {7'd0, halted}, 8'h01);
        check("rerun final pc", pc, 8'h06);

        for (int t = 0; t < 8; t++) random_program(t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asap1_cpu.md
Name: asap1_cpu

Overview:
- Self-contained 8-bit SAP-1-style CPU core.
- Contains a microcoded control unit, an add/subtract ALU with carry and zero flags, and a 256x8 RAM.
- Also holds the A, B, MAR, IR, OUT and PC registers, all on one internal 8-bit bus.
- Sits at the top of the asap1 design. Software is loaded through a program port while in reset; results appear on `out`.

Parameters:
- MEM_DEPTH, 256, RAM words; address is 8 bits, upper addresses unused if smaller.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  RAM program write strobe; honoured only while rst=1.
- prog_addr  in  8  program write address.
- prog_data  in  8  program write data.
- out  out  8  output register contents.
- halted  out  1  high once HLT executes; cleared only by rst.
- pc  out  8  program counter, for debug.

Behaviour:
- Reset:
  - A, B, MAR, IR, OUT, PC, flags (cf, zf), step counter and halted all go to 0.
  - RAM is not cleared.
  - While rst=1, a prog_we on a rising edge writes prog_data to RAM[prog_addr].
- Bus:
  - Exactly one source per cycle, selected by the output enables AO, BO, ALO, PCO, MO.
  - No enable active -> bus = 0x00.
  - Control never asserts two output enables at once.
- Control word bits: AI, AO, BI, BO, MAI, OUI, II, ALO, ALS, PCI, PCO, PCS, MI, MO, HLT.
- Control word is combinational from IR, step, cf and zf.
- Loads: any "I" signal loads the bus into its register on the rising edge.
- PC:
  - PCS increments PC, wrapping 0xFF->0x00.
  - PCI loads PC from the bus; PCI takes priority over PCS.
- RAM:
  - Asynchronous read of RAM[MAR] onto the bus under MO.
  - Synchronous write of the bus under MI.
- ALU:
  - Result = A+B, or A+~B+1 when ALS=1.
  - Driven onto the bus under ALO.
  - On an ALO edge, cf <= carry-out of bit 7 (for SUB, cf=1 means no borrow) and zf <= (result==0).
  - Flags are held otherwise.
- Step counter:
  - Counts T0..T5 and returns to T0 on the edge after the instruction's last step.
- Fetch steps:
  - T0: PCO|MAI.
  - T1: MO|II|PCS.
- Instructions are two bytes (opcode, operand) unless noted. "Operand fetch" means T2: PCO|MAI; T3: MO|MAI|PCS.
- Execute sequences:
  - 0x00 NOP: 2 cycles.
  - 0x01 LDA a: operand fetch; T4 MO|AI. 5 cycles.
  - 0x02 ADD a: operand fetch; T4 MO|BI; T5 ALO|AI. 6 cycles.
  - 0x03 SUB a: as ADD, with T5 ALO|ALS|AI.
  - 0x04 STA a: operand fetch; T4 AO|MI.
  - 0x05 LDI imm: T2 PCO|MAI; T3 MO|AI|PCS. 4 cycles.
  - 0x06 JMP a: T2 PCO|MAI; T3 MO|PCI. 4 cycles.
  - 0x07 JC a: behaves as JMP if cf=1; otherwise T2 PCS, 3 cycles.
  - 0x08 JZ a: as JC, using zf.
  - 0x0E OUT: T2 AO|OUI. 3 cycles.
  - 0x0F HLT: T2 asserts HLT. halted sets and the step counter freezes; no further bus activity.
  - Any other opcode: treated as NOP.
- Reset asserted mid-instruction aborts it immediately; execution restarts at T0 with PC=0.

Decomposition:
- Shared package asap1_pkg holds:
  - control-bit index constants and CONTROL_SIGNALS (=15);
  - opcode constants;
  - the step-index constants T0..T5.
- One natural sub-module: asap1_alu (adder/subtractor plus flag register).
- Control decode, RAM and registers stay in the top-level module.

Test Plan:
- Load LDI 5; ADD 0x20; OUT; HLT with RAM[0x20]=3; release reset -> out=0x08 after 4+6+3 cycles, cf=0, zf=0, then halted=1 and pc=0x06 held.
- A=0x03, SUB of a location holding 0x03 -> A=0x00, zf=1, cf=1; following JZ 0x10 -> pc=0x10 after 4 cycles.
- A=0x02, SUB 0x03 -> A=0xFF, cf=0, zf=0; JC not taken -> pc advances by 2 in 3 cycles.
- A=0xFF, ADD 0x01 -> A=0x00, cf=1, zf=1; JC 0x30 taken.
- STA 0x40 with A=0x5A, then LDI 0; LDA 0x40; OUT -> out=0x5A.
- Assert rst during T4 of ADD -> every register, flag and the step counter read 0 immediately; out=0; RAM program intact; re-run from pc=0 gives the same results.
